alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 4-bit single-cycle ALU: WIDTH-bit datapath, valid/ready input handshake, a single-cycle path for logic, add and shift operations, and an iterative shift-add multiplier and restoring divider that share one busy state machine. It sits between the register-file read stage and write-back, driving `write_enable` to the register file. It adds signed overflow, negative, divide-by-zero and remainder/compare behaviour that the 4-bit ALU lacks.

## Interface
- `WIDTH`, 8: operand/result width, ≥ 2.
- `clk`  in  1  rising-edge clock, sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; 1 only in IDLE and not in reset.
- `operand1`, `operand2`  in  WIDTH  operands, sampled on accept edge only.
- `alu_op`  in  4  operation code, sampled on accept edge only.
- `result`  out  WIDTH  registered result, held until next completion.
- `out_valid`  out  1  one-cycle completion pulse.
- `zero_flag`, `carry_flag`, `overflow_flag`, `negative_flag`, `div_zero_flag`  out  1 each  registered flags, updated only on completion, held otherwise.
- `write_enable`  out  1  one-cycle pulse coincident with `out_valid` for writing ops.

## Operation
- Accept = `in_valid && in_ready` at a rising edge.
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL (low WIDTH bits), 0011 DIV (unsigned quotient), 0100 AND, 0101 OR, 0110 XOR, 0111 XNOR, 1000 NOT op1, 1001 SHR by 1 (logical), 1010 SHL by 1, 1011 SAR by 1 (arithmetic), 1100 REM (unsigned remainder), 1101 CMP (op1−op2, no write-back); 1110/1111 undefined.
- ADD: {carry, result} = op1 + op2 (WIDTH+1 bits). SUB/CMP: carry = borrow (op1 < op2 unsigned).
- overflow: ADD/SUB/CMP signed two's-complement overflow; 0 for all other ops.
- SHL: carry = op1[WIDTH-1]. SHR/SAR: carry = op1[0]. MUL: carry = 1 iff upper WIDTH bits of full product ≠ 0. All others: carry 0.
- zero = (result == 0); negative = result[WIDTH-1]; both computed on every completion.
- DIV/REM with op2 == 0: single-cycle completion, result 0, div_zero_flag 1, carry/overflow 0, write_enable 1. div_zero_flag 0 on every other completion.
- Undefined op: single-cycle completion, result 0, zero 1, all other flags 0, write_enable 0.
- write_enable = out_valid for every defined op except CMP.
- States: IDLE → IDLE on single-cycle accept; IDLE → MUL on MUL accept; IDLE → DIV on DIV/REM accept with op2 ≠ 0; MUL/DIV → IDLE after WIDTH iterations, the last of which registers result/flags and pulses out_valid.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. DIV: restoring, one quotient bit per cycle, MSB first; REM returns the final partial remainder.
- `in_valid` while busy is ignored (not queued); requester holds request until `in_ready`.

## Timing
- Reset (rst high at an edge): state IDLE; result 0; all flags 0; out_valid 0; write_enable 0. in_ready 0 while rst is high, 1 in the first cycle after deassertion.
- Reset mid-MUL/DIV aborts the operation: no out_valid, outputs take reset values.
- Single-cycle ops: accept edge E0 registers result/flags; out_valid high for the cycle after E0. in_ready stays 1, giving back-to-back throughput of one op per cycle.
- MUL, DIV/REM (op2 ≠ 0): accept at E0, iterations at E1..E(WIDTH), out_valid high for the cycle after E(WIDTH). in_ready is 0 for the WIDTH cycles after E0 and returns to 1 in the out_valid cycle, so a new accept may occur at the same edge that ends the out_valid pulse.
- out_valid and write_enable never assert for more than one consecutive cycle per operation.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 → result 0x00, zero 1, carry 1, overflow 0, out_valid one cycle after accept; ADD 0x7F+0x01 → 0x80, overflow 1, negative 1.
- SUB 0x03−0x05 → 0xFE, carry 1, negative 1; CMP 0x05,0x05 → zero 1, write_enable 0, out_valid 1.
- MUL 0x10×0x11 → 0x10, carry 1; in_ready low 8 cycles; out_valid after edge E8; in_valid toggled while busy has no effect.
- DIV 200/7 → 28; REM 200/7 → 4; DIV 9/0 → result 0, div_zero 1, single-cycle latency.
- Back-to-back AND, SHL 0x81 (→0x02, carry 1), SAR 0x80 (→0xC0), undefined 1111 (→0, zero 1, write_enable 0): one result per cycle.
- rst asserted on the 3rd busy cycle of DIV → no out_valid, all outputs 0, in_ready 1 the cycle after rst drops.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked WIDTH-bit ALU with iterative multiply and divide
//
// Single-cycle logic/add/shift ops complete on the accept edge; MUL (shift-add)
// and DIV/REM (restoring) iterate one bit per cycle and share a busy FSM.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid / in_ready       request handshake (ready only in IDLE, not in reset)
//   operand1, operand2        WIDTH-bit operands, sampled on the accept edge
//   alu_op                    4-bit opcode, sampled on the accept edge
//   result                    registered result, held until the next completion
//   out_valid                 one-cycle completion pulse
//   zero/carry/overflow/negative/div_zero_flag  registered completion flags
//   write_enable              one-cycle pulse with out_valid for writing ops
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             negative_flag,
    output logic             div_zero_flag,
    output logic             write_enable
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_XNOR = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_SAR  = 4'b1011;
    localparam logic [3:0] OP_REM  = 4'b1100;
    localparam logic [3:0] OP_CMP  = 4'b1101;

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic                 out_valid_q, out_valid_d;
    logic                 we_q, we_d;

    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 is_rem_q, is_rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 accept;
    logic                 last_iter;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH:0]       r_shift;
    logic [WIDTH:0]       trial;
    logic                 fits;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;

    logic [WIDTH-1:0]     res_v;
    logic                 carry_v;
    logic                 ovf_v;
    logic                 dz_v;
    logic                 we_v;
    logic                 done_v;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Top bit of the extended difference is the unsigned borrow.
    assign sum_ext  = {1'b0, operand1} + {1'b0, operand2};
    assign diff_ext = {1'b0, operand1} - {1'b0, operand2};
    assign add_ovf  = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != operand1[WIDTH-1]);
    assign sub_ovf  = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != operand1[WIDTH-1]);

    // Multiplicand shifts left each step while multiplier bits are consumed LSB first.
    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Restoring step: bring in the next dividend bit (MSB first, held in quo_q)
    // and subtract if it fits; trial[WIDTH] set means the subtraction borrowed.
    assign r_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial   = r_shift - {1'b0, divisor_q};
    assign fits    = !trial[WIDTH];
    assign rem_nxt = fits ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], fits};

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        dz_d        = dz_q;
        out_valid_d = 1'b0;
        we_d        = 1'b0;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        is_rem_d    = is_rem_q;
        cnt_d       = cnt_q;

        res_v   = '0;
        carry_v = 1'b0;
        ovf_v   = 1'b0;
        dz_v    = 1'b0;
        we_v    = 1'b1;
        done_v  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    done_v = 1'b1;
                    case (alu_op)
                        OP_ADD: begin
                            res_v   = sum_ext[WIDTH-1:0];
                            carry_v = sum_ext[WIDTH];
                            ovf_v   = add_ovf;
                        end
                        OP_SUB, OP_CMP: begin
                            res_v   = diff_ext[WIDTH-1:0];
                            carry_v = diff_ext[WIDTH];
                            ovf_v   = sub_ovf;
                            we_v    = (alu_op == OP_SUB);
                        end
                        OP_MUL: begin
                            done_v   = 1'b0;
                            state_d  = S_MUL;
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, operand1};
                            mplier_d = operand2;
                            cnt_d    = '0;
                        end
                        OP_DIV, OP_REM: begin
                            if (operand2 == '0) begin
                                dz_v = 1'b1;
                            end else begin
                                done_v    = 1'b0;
                                state_d   = S_DIV;
                                rem_d     = '0;
                                quo_d     = operand1;
                                divisor_d = operand2;
                                is_rem_d  = (alu_op == OP_REM);
                                cnt_d     = '0;
                            end
                        end
                        OP_AND:  res_v = operand1 & operand2;
                        OP_OR:   res_v = operand1 | operand2;
                        OP_XOR:  res_v = operand1 ^ operand2;
                        OP_XNOR: res_v = ~(operand1 ^ operand2);
                        OP_NOT:  res_v = ~operand1;
                        OP_SHR: begin
                            res_v   = {1'b0, operand1[WIDTH-1:1]};
                            carry_v = operand1[0];
                        end
                        OP_SHL: begin
                            res_v   = {operand1[WIDTH-2:0], 1'b0};
                            carry_v = operand1[WIDTH-1];
                        end
                        OP_SAR: begin
                            res_v   = {operand1[WIDTH-1], operand1[WIDTH-1:1]};
                            carry_v = operand1[0];
                        end
                        default: we_v = 1'b0;
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    done_v  = 1'b1;
                    state_d = S_IDLE;
                    res_v   = acc_nxt[WIDTH-1:0];
                    carry_v = |acc_nxt[2*WIDTH-1:WIDTH];
                end
            end
            S_DIV: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    done_v  = 1'b1;
                    state_d = S_IDLE;
                    res_v   = is_rem_q ? rem_nxt : quo_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done_v) begin
            result_d    = res_v;
            zero_d      = (res_v == '0);
            neg_d       = res_v[WIDTH-1];
            carry_d     = carry_v;
            ovf_d       = ovf_v;
            dz_d        = dz_v;
            out_valid_d = 1'b1;
            we_d        = we_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            we_q        <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            is_rem_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            we_q        <= we_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            is_rem_q    <= is_rem_d;
            cnt_q       <= cnt_d;
        end
    end

    assign result        = result_q;
    assign out_valid     = out_valid_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;
    assign negative_flag = neg_q;
    assign div_zero_flag = dz_q;
    assign write_enable  = we_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic model
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [3:0]   alu_op;
    logic [W-1:0] result;
    logic         out_valid;
    logic         zero_flag;
    logic         carry_flag;
    logic         overflow_flag;
    logic         negative_flag;
    logic         div_zero_flag;
    logic         write_enable;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .operand1      (operand1),
        .operand2      (operand2),
        .alu_op        (alu_op),
        .result        (result),
        .out_valid     (out_valid),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .negative_flag (negative_flag),
        .div_zero_flag (div_zero_flag),
        .write_enable  (write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {zero, carry, overflow, negative, div_zero}
    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   flags;
        logic         we;
        int           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   flags;
        logic         we;
        logic         ov;
        int           lat;
        int           busy;
        logic         ov_after;
        logic         we_after;
        logic         ready_at_req;
    } obs_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [4:0]   f;
        logic         we;
        logic [7:0]   lat;
    } vec_t;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, full, s;
        logic z, c, v, dz;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        full = 0;
        c = 1'b0; v = 1'b0; dz = 1'b0;
        e.we = 1'b1;
        e.lat = 1;
        case (op)
            4'd0: begin
                full = ua + ub; c = (full >= (1 << W));
                s = sa + sb; v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
            end
            4'd1, 4'd13: begin
                full = ua - ub; c = (ua < ub);
                s = sa - sb; v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
                e.we = (op == 4'd1);
            end
            4'd2: begin
                full = ua * ub; c = (full >= (1 << W)); e.lat = W + 1;
            end
            4'd3, 4'd12: begin
                if (ub == 0) dz = 1'b1;
                else begin
                    full = (op == 4'd3) ? ua / ub : ua % ub;
                    e.lat = W + 1;
                end
            end
            4'd4:  full = ua & ub;
            4'd5:  full = ua | ub;
            4'd6:  full = ua ^ ub;
            4'd7:  full = ~(ua ^ ub);
            4'd8:  full = ~ua;
            4'd9:  begin full = ua / 2; c = a[0]; end
            4'd10: begin full = ua * 2; c = a[W-1]; end
            4'd11: begin full = sa >>> 1; c = a[0]; end
            default: e.we = 1'b0;
        endcase
        e.res = full[W-1:0];
        z = (e.res == 0);
        e.flags = {z, c, v, e.res[W-1], dz};
        return e;
    endfunction

    // Issues one request from just after a negedge and follows it to completion.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise, output obs_t o);
        o.ready_at_req = in_ready;
        alu_op   = op;
        operand1 = a;
        operand2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        o.lat  = 1;
        o.busy = 0;
        while (!out_valid && o.lat < 40) begin
            if (!in_ready) o.busy++;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                operand1 = W'($urandom);
                operand2 = W'($urandom);
                alu_op   = 4'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
            o.lat++;
        end
        o.ov    = out_valid;
        o.res   = result;
        o.flags = {zero_flag, carry_flag, overflow_flag, negative_flag, div_zero_flag};
        o.we    = write_enable;
        @(negedge clk);
        o.ov_after = out_valid;
        o.we_after = write_enable;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        operand1 = '0;
        operand2 = '0;
        alu_op = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({result, zero_flag, carry_flag, overflow_flag, negative_flag, div_zero_flag,
             out_valid, write_enable} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got res=%h flags=%b%b%b%b%b ov=%b we=%b, want all 0",
                     result, zero_flag, carry_flag, overflow_flag, negative_flag, div_zero_flag,
                     out_valid, write_enable);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed;
        vec_t v [11];
        obs_t o;
        v = '{
            '{4'h0, 8'hFF, 8'h01, 8'h00, 5'b11000, 1'b1, 8'd1},
            '{4'h0, 8'h7F, 8'h01, 8'h80, 5'b00110, 1'b1, 8'd1},
            '{4'h1, 8'h03, 8'h05, 8'hFE, 5'b01010, 1'b1, 8'd1},
            '{4'hD, 8'h05, 8'h05, 8'h00, 5'b10000, 1'b0, 8'd1},
            '{4'h2, 8'h10, 8'h11, 8'h10, 5'b01000, 1'b1, 8'd9},
            '{4'h3, 8'd200, 8'd7, 8'd28, 5'b00000, 1'b1, 8'd9},
            '{4'hC, 8'd200, 8'd7, 8'd4, 5'b00000, 1'b1, 8'd9},
            '{4'h3, 8'd9, 8'd0, 8'h00, 5'b10001, 1'b1, 8'd1},
            '{4'hA, 8'h81, 8'h00, 8'h02, 5'b01000, 1'b1, 8'd1},
            '{4'hB, 8'h80, 8'h00, 8'hC0, 5'b00010, 1'b1, 8'd1},
            '{4'hF, 8'h12, 8'h34, 8'h00, 5'b10000, 1'b0, 8'd1}
        };
        for (int i = 0; i < 11; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, 1'b1, o);
            n_cmp++;
            if (o.res !== v[i].r || o.flags !== v[i].f || o.we !== v[i].we || o.ov !== 1'b1) begin
                n_fail++;
                $display("FAIL directed[%0d] op=%h: got res=%h flags=%b we=%b ov=%b, want res=%h flags=%b we=%b ov=1",
                         i, v[i].op, o.res, o.flags, o.we, o.ov, v[i].r, v[i].f, v[i].we);
            end
            n_cmp++;
            if (o.lat !== int'(v[i].lat) || o.busy !== int'(v[i].lat) - 1) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
                         i, o.lat, o.busy, v[i].lat, int'(v[i].lat) - 1);
            end
            n_cmp++;
            if (o.ov_after !== 1'b0 || o.we_after !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_pulse[%0d]: got ov=%b we=%b after pulse, want 0 0",
                         i, o.ov_after, o.we_after);
            end
        end
    endtask

    task automatic test_random;
        obs_t o;
        exp_t e;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            e  = model(op, a, b);
            do_op(op, a, b, 1'b1, o);
            n_cmp++;
            if (o.res !== e.res || o.flags !== e.flags || o.we !== e.we || o.ov !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: got res=%h flags=%b we=%b ov=%b, want res=%h flags=%b we=%b ov=1",
                         i, op, a, b, o.res, o.flags, o.we, o.ov, e.res, e.flags, e.we);
            end
            n_cmp++;
            if (o.lat !== e.lat || o.busy !== e.lat - 1 || o.ready_at_req !== 1'b1) begin
                n_fail++;
                $display("FAIL random_timing[%0d] op=%h: got lat=%0d busy=%0d ready=%b, want lat=%0d busy=%0d ready=1",
                         i, op, o.lat, o.busy, o.ready_at_req, e.lat, e.lat - 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   ops [$];
        logic [W-1:0] as [$];
        logic [W-1:0] bs [$];
        logic [3:0]   pool [13];
        exp_t         e;
        pool = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
        ops = '{4'h4, 4'hA, 4'hB, 4'hF};
        as  = '{8'hF0, 8'h81, 8'h80, 8'h55};
        bs  = '{8'h3C, 8'h00, 8'h00, 8'hAA};
        for (int i = 0; i < 20; i++) begin
            ops.push_back(pool[$urandom_range(0, 12)]);
            as.push_back(W'($urandom));
            bs.push_back(W'($urandom));
        end
        ops.push_back(4'h3); as.push_back(8'h09); bs.push_back(8'h00);
        ops.push_back(4'hC); as.push_back(8'hFF); bs.push_back(8'h00);
        for (int i = 0; i <= ops.size(); i++) begin
            if (i < ops.size()) begin
                in_valid = 1'b1;
                alu_op   = ops[i];
                operand1 = as[i];
                operand2 = bs[i];
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                e = model(ops[i-1], as[i-1], bs[i-1]);
                n_cmp++;
                if (out_valid !== 1'b1 || result !== e.res || write_enable !== e.we ||
                    {zero_flag, carry_flag, overflow_flag, negative_flag, div_zero_flag} !== e.flags) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] op=%h: got ov=%b res=%h flags=%b%b%b%b%b we=%b, want ov=1 res=%h flags=%b we=%b",
                             i - 1, ops[i-1], out_valid, result, zero_flag, carry_flag, overflow_flag,
                             negative_flag, div_zero_flag, write_enable, e.res, e.flags, e.we);
                end
            end
            if (i < ops.size()) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got ov=%b we=%b want 0 0", out_valid, write_enable);
        end
    endtask

    task automatic test_reset_mid_div;
        int seen;
        obs_t o;
        do_op(4'h0, 8'h12, 8'h34, 1'b0, o);
        in_valid = 1'b1;
        alu_op   = 4'h3;
        operand1 = 8'd200;
        operand2 = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        seen = out_valid;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_div_ready_in_rst: got %b want 0", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({result, zero_flag, carry_flag, overflow_flag, negative_flag, div_zero_flag,
             out_valid, write_enable, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL mid_div_reset_outputs: got res=%h ov=%b we=%b ready=%b flags=%b%b%b%b%b, want all 0",
                     result, out_valid, write_enable, in_ready, zero_flag, carry_flag,
                     overflow_flag, negative_flag, div_zero_flag);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_div_ready_after: got %b want 1", in_ready);
        end
        for (int k = 0; k < 12; k++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0 || result !== '0) begin
            n_fail++;
            $display("FAIL mid_div_aborted: got %0d out_valid pulses res=%h, want 0 pulses res=00",
                     seen, result);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
